apb_slave_regfile: RTL

APB completer that sits directly downstream of the APB master on the same PCLK domain. It decodes one PSEL line and serves reads and writes from an internal register file of MEM_DEPTH words. It returns PRDATA, PREADY and PSLVERR to the master; its PRDATA feeds the master's read-data input. Wait-state insertion is configurable, and out-of-range accesses are flagged with PSLVERR.

---
 rtl/apb_slave_regfile.sv | 135 +++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : APB completer serving a MEM_DEPTH-word register file; flags
//               out-of-range accesses with PSLVERR. Define APB_SLAVE_WAIT_EN
//               to add WAIT_CYCLES extra wait states per access.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int          c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned c_depth = MEM_DEPTH;
`ifdef APB_SLAVE_WAIT_EN
    localparam int          c_cnt_w = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];
`ifdef APB_SLAVE_WAIT_EN
    logic [c_cnt_w-1:0]      r_cnt;
`endif

    logic w_in_range;
    logic w_exec;

    // Full-width compare so that addresses above MEM_DEPTH never alias.
    assign w_in_range = (32'(r_addr) < c_depth);

`ifdef APB_SLAVE_WAIT_EN
    assign w_exec = (r_cnt == '0);
`else
    assign w_exec = 1'b1;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
`ifdef APB_SLAVE_WAIT_EN
            r_cnt   <= '0;
`endif
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    // PSEL with PENABLE already high is a protocol violation and is ignored.
                    if (PSEL && !PENABLE) begin
                        r_addr  <= PADDR;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
`ifdef APB_SLAVE_WAIT_EN
                        r_cnt   <= c_cnt_w'(WAIT_CYCLES);
`endif
                        r_state <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (!PSEL || !PENABLE) begin
                        r_state <= S_IDLE;
                    end else if (!w_exec) begin
`ifdef APB_SLAVE_WAIT_EN
                        r_cnt <= r_cnt - 1'b1;
`endif
                    end else begin
                        if (!w_in_range) begin
                            PRDATA  <= '0;
                            PSLVERR <= 1'b1;
                        end else if (r_write) begin
                            r_mem[r_addr[c_idx_w-1:0]] <= r_wdata;
                            PRDATA  <= '0;
                            PSLVERR <= 1'b0;
                        end else begin
                            PRDATA  <= r_mem[r_addr[c_idx_w-1:0]];
                            PSLVERR <= 1'b0;
                        end
                        PREADY  <= 1'b1;
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    r_state <= S_IDLE;
                end

                default: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
